song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Steps through a song ROM note by note and times each note in milliseconds.
//  Drives the sound engine (gate/octave/note) and tells the scoring logic when each note starts.
//  Opens a hit window at the start of each note for the scoring logic.
//  Sits between the mode FSM (start/pause/abort, song and mod select) and the Song ROM + Sound datapath.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency; 1 ms tick = CLK_HZ/1000 cycles
//  UNIT_MS    125          ms per length-code unit
//  GAP_MS     20           silent gap between notes, ms
//  WINDOW_MS  150          hit-window length from note start, ms
//  ADDR_W     8            ROM note-index width
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous reset, active-high
//  start        in   1       one-cycle pulse: begin playing song_sel
//  pause        in   1       level: freeze timing, mute gate
//  abort        in   1       one-cycle pulse: stop and return to IDLE
//  song_sel     in   3       song number, latched on start
//  mod          in   2       0 Normal, 1 NoFail, 2 HalfTime, 3 DoubleTime; latched on start
//  track_len    in   ADDR_W  note count of the selected song (from ROM, valid while song_out is stable)
//  rom_octave   in   3       ROM data, valid 1 cycle after rom_addr changes
//  rom_note     in   3       ROM data; 0 = rest
//  rom_length   in   4       ROM data, duration in units; 0 is treated as 1
//  song_out     out  3       latched song number, to ROM
//  rom_addr     out  ADDR_W  current note index, to ROM
//  snd_gate     out  1       sound engine enable
//  snd_octave   out  3       latched octave
//  snd_note     out  3       latched note
//  note_strobe  out  1       one-cycle pulse at each note start
//  window_open  out  1       high during the hit window
//  busy         out  1       high in every state except IDLE
//  finished     out  1       one-cycle pulse after the last note's gap
// BEHAVIOUR
//  Reset values
//   - All outputs are 0; state = IDLE; all counters = 0.
//  States
//   - IDLE
//     - On start with abort=0: latch song_sel and mod, set rom_addr=0, go to LOAD.
//   - LOAD
//     - Waits one cycle so track_len becomes valid for the new song_out.
//     - track_len==0 -> DONE; otherwise -> FETCH.
//   - FETCH
//     - One wait cycle for ROM latency.
//     - On exit: latch octave/note, compute dur_ms, pulse note_strobe, go to PLAY.
//   - PLAY
//     - snd_gate = (note!=0) & ~pause.
//     - Counts ms ticks; after dur_ms ticks -> GAP.
//   - GAP
//     - snd_gate=0; counts GAP_MS ticks.
//     - If rom_addr==track_len-1 -> DONE; else rom_addr+1 -> FETCH.
//   - DONE
//     - finished=1 for one cycle, then -> IDLE.
//  Duration arithmetic (16-bit, no overflow possible)
//   - base = max(length,1)*UNIT_MS.
//   - mod 2: dur_ms = base<<1.
//   - mod 3: dur_ms = base>>1, minimum 1.
//   - otherwise: dur_ms = base.
//  Timing
//   - The prescaler and ms counter clear on every state entry.
//   - They advance only in PLAY/GAP and only while pause=0.
//   - Pause mid-note resumes with no ms lost or gained.
//   - window_open=1 from the note_strobe cycle while PLAY ms count < min(WINDOW_MS, dur_ms); it stays asserted while paused.
//  Boundaries and priority
//   - abort in any state -> IDLE next cycle; gate, window and strobe drop at once.
//   - abort beats start in the same cycle.
//   - start while busy is ignored.
//   - song_sel/mod changes while busy have no effect.
//   - pause in IDLE, LOAD, FETCH or DONE has no effect.
//   - rom_addr holds its last value in IDLE.
// TESTING  (sim with CLK_HZ=1000 so 1 tick = 1 cycle; UNIT_MS=4, GAP_MS=2, WINDOW_MS=3)
//  1. rst high mid-PLAY -> all outputs 0 immediately, even without a clk edge.
//  2. Song of 3 notes with length 1,2,1, mod 0 -> gate high 4/8/4 cycles, each followed by a 2-cycle gap.
//     -> 3 note_strobe pulses, then finished exactly once, busy drops the cycle after.
//  3. Same song, mod 2 -> gate 8/16/8 cycles; mod 3 -> gate 2/4/2 cycles.
//  4. pause for 5 cycles during the second note -> gate low for those 5 cycles; total note time extends by exactly 5.
//  5. abort together with start; then abort during GAP -> stays in IDLE; then IDLE next cycle, finished never pulses.
//  6. rest note (note=0, length=1) -> gate stays 0 for 4 cycles, note_strobe and window_open still asserted.
//     track_len=0 -> finished pulses two cycles after start, no strobe.

Source files
------------

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - song ROM note stepper with millisecond note timing and hit window
//
// Purpose: walks the selected song in the Song ROM one note at a time,
// drives the sound engine with each note's octave/note and a gate for the
// note's duration, then holds a silent gap before the next note. Each note
// start is flagged with a one-cycle strobe, and a hit window opens for
// the scoring logic.
//
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   start, pause, abort         control from the mode FSM
//   song_sel, mod               song number and play modifier, latched on start
//   track_len                   note count of the song on song_out
//   rom_octave/note/length      ROM data for the note at rom_addr
//   song_out, rom_addr          ROM address
//   snd_gate, snd_octave/note   sound engine drive
//   note_strobe, window_open    note-start pulse and hit window for scoring
//   busy, finished              activity level and end-of-song pulse

module song_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int UNIT_MS   = 125,
  parameter int GAP_MS    = 20,
  parameter int WINDOW_MS = 150,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [2:0]        song_sel,
  input  logic [1:0]        mod,
  input  logic [ADDR_W-1:0] track_len,
  input  logic [2:0]        rom_octave,
  input  logic [2:0]        rom_note,
  input  logic [3:0]        rom_length,
  output logic [2:0]        song_out,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              snd_gate,
  output logic [2:0]        snd_octave,
  output logic [2:0]        snd_note,
  output logic              note_strobe,
  output logic              window_open,
  output logic              busy,
  output logic              finished
);

  localparam int TICK  = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK - 1);
  localparam logic [15:0] UNIT16 = 16'(UNIT_MS);
  localparam logic [15:0] GAP16  = 16'(GAP_MS);
  localparam logic [15:0] WIN16  = 16'(WINDOW_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [1:0]        mod_q;
  logic [PRE_W-1:0]  pre;
  logic [15:0]       ms_cnt;
  logic [15:0]       dur_ms;
  logic [15:0]       dur_calc;
  logic [15:0]       base;
  logic [15:0]       half;
  logic [3:0]        len_eff;
  logic              strobe_q;
  logic              timing;
  logic              ms_tick;
  logic              last_note;

  // Duration of the note currently on the ROM bus, in ms.
  always_comb begin
    len_eff  = (rom_length == 4'd0) ? 4'd1 : rom_length;
    base     = {12'd0, len_eff} * UNIT16;
    half     = base >> 1;
    dur_calc = base;
    case (mod_q)
      2'd2:    dur_calc = base << 1;
      2'd3:    dur_calc = (half == 16'd0) ? 16'd1 : half;
      default: dur_calc = base;
    endcase
  end

  assign timing    = (state == S_PLAY) || (state == S_GAP);
  assign ms_tick   = timing && !pause && (pre == PRE_LAST);
  assign last_note = (rom_addr == track_len - ADDR_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD:  state_n = (track_len == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_n = S_PLAY;
      S_PLAY:  if (ms_tick && ms_cnt == dur_ms - 16'd1) state_n = S_GAP;
      S_GAP:   if (ms_tick && ms_cnt == GAP16 - 16'd1) state_n = last_note ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  // Timing counters and latched song/note data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre        <= '0;
      ms_cnt     <= '0;
      dur_ms     <= '0;
      mod_q      <= '0;
      song_out   <= '0;
      rom_addr   <= '0;
      snd_octave <= '0;
      snd_note   <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      // Clearing on every state change means each PLAY/GAP starts from zero;
      // holding while paused preserves the exact ms position.
      if (state_n != state) begin
        pre    <= '0;
        ms_cnt <= '0;
      end else if (timing && !pause) begin
        if (pre == PRE_LAST) begin
          pre    <= '0;
          ms_cnt <= ms_cnt + 16'd1;
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            song_out <= song_sel;
            mod_q    <= mod;
            rom_addr <= '0;
          end
        end
        S_FETCH: begin
          if (state_n == S_PLAY) begin
            snd_octave <= rom_octave;
            snd_note   <= rom_note;
            dur_ms     <= dur_calc;
            strobe_q   <= 1'b1;
          end
        end
        S_GAP: begin
          if (state_n == S_FETCH) rom_addr <= rom_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs; abort silences gate, window and strobe in its own cycle.
  always_comb begin
    busy        = (state != S_IDLE);
    finished    = (state == S_DONE);
    snd_gate    = (state == S_PLAY) && (snd_note != 3'd0) && !pause && !abort;
    window_open = (state == S_PLAY) && (ms_cnt < WIN16) && !abort;
    note_strobe = (state == S_PLAY) && strobe_q && !abort;
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer

module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] song_sel = '0;
  logic [1:0] mod = '0;
  logic [7:0] track_len;
  logic [2:0] rom_octave, rom_note;
  logic [3:0] rom_length;
  logic [2:0] song_out;
  logic [7:0] rom_addr;
  logic       snd_gate;
  logic [2:0] snd_octave, snd_note;
  logic       note_strobe, window_open, busy, finished;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  song_sequencer #(
    .CLK_HZ(1000), .UNIT_MS(4), .GAP_MS(2), .WINDOW_MS(3), .ADDR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .song_sel(song_sel), .mod(mod), .track_len(track_len),
    .rom_octave(rom_octave), .rom_note(rom_note), .rom_length(rom_length),
    .song_out(song_out), .rom_addr(rom_addr), .snd_gate(snd_gate),
    .snd_octave(snd_octave), .snd_note(snd_note), .note_strobe(note_strobe),
    .window_open(window_open), .busy(busy), .finished(finished)
  );

  // Song ROM contents
  logic [2:0] oct_t [0:7][0:3];
  logic [2:0] note_t[0:7][0:3];
  logic [3:0] len_t [0:7][0:3];
  logic [7:0] tl_t  [0:7];

  assign rom_octave = oct_t[song_out][rom_addr[1:0]];
  assign rom_note   = note_t[song_out][rom_addr[1:0]];
  assign rom_length = len_t[song_out][rom_addr[1:0]];
  assign track_len  = tl_t[song_out];

  typedef struct packed {
    int               song;
    int               md;
    int               n;
    int               pnote;
    int               plen;
    logic [2:0][15:0] gate;
    logic [2:0][15:0] per;
    logic [2:0][15:0] win;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input int s, input int m, input int n, input int pn, input int pl,
                              input int g0, input int g1, input int g2,
                              input int p0, input int p1, input int p2,
                              input int w0, input int w1, input int w2);
    vec_t v;
    v.song = s; v.md = m; v.n = n; v.pnote = pn; v.plen = pl;
    v.gate = {16'(g2), 16'(g1), 16'(g0)};
    v.per  = {16'(p2), 16'(p1), 16'(p0)};
    v.win  = {16'(w2), 16'(w1), 16'(w0)};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int out_word();
    return int'({song_out, rom_addr, snd_gate, snd_octave, snd_note,
                 note_strobe, window_open, busy, finished});
  endfunction

  // per = cycles from a note's strobe to the next strobe (or to DONE for the last note)
  task automatic run_vec(input int idx);
    vec_t v;
    int gate_c[3];
    int per_c[3];
    int win_c[3];
    int k, cyc, strobes, fins, fin_cyc, pleft;
    v = vecs[idx];
    for (int i = 0; i < 3; i++) begin gate_c[i] = 0; per_c[i] = 0; win_c[i] = 0; end
    k = -1; cyc = 0; strobes = 0; fins = 0; fin_cyc = -1; pleft = 0;
    @(negedge clk);
    song_sel = 3'(v.song); mod = 2'(v.md); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    song_sel = 3'd2;          // changes while busy must be ignored
    mod = ~2'(v.md);
    while (cyc < 300) begin
      if (!busy) break;
      if (note_strobe) begin
        strobes++;
        if (k < 2) k++;
        chk($sformatf("v%0d_note%0d", idx, k), int'(snd_note), int'(note_t[v.song][k]));
        chk($sformatf("v%0d_oct%0d", idx, k), int'(snd_octave), int'(oct_t[v.song][k]));
      end
      if (finished) begin fins++; fin_cyc = cyc; end
      if (k >= 0 && !finished) begin
        per_c[k]++;
        if (snd_gate) gate_c[k]++;
        if (window_open) win_c[k]++;
      end
      start = (k == 0 && per_c[0] == 2);   // start while busy
      if (k >= 0 && k == v.pnote && per_c[k] == 4 && pleft == 0) pleft = v.plen;
      if (pleft > 0) begin pause = 1'b1; pleft--; end
      else pause = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; pause = 1'b0;
    chk($sformatf("v%0d_idle", idx), int'(busy), 0);
    chk($sformatf("v%0d_strobes", idx), strobes, v.n);
    chk($sformatf("v%0d_finished", idx), fins, 1);
    chk($sformatf("v%0d_busy_drop", idx), fin_cyc, cyc - 1);
    chk($sformatf("v%0d_song_out", idx), int'(song_out), v.song);
    chk($sformatf("v%0d_addr_hold", idx), int'(rom_addr), v.n - 1);
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("v%0d_gate%0d", idx, i), gate_c[i], int'(v.gate[i]));
      chk($sformatf("v%0d_per%0d", idx, i), per_c[i], int'(v.per[i]));
      chk($sformatf("v%0d_win%0d", idx, i), win_c[i], int'(v.win[i]));
    end
  endtask

  initial begin
    int cnt, fin_c, busy_c, seen;
    for (int s = 0; s < 8; s++) begin
      tl_t[s] = 8'd0;
      for (int a = 0; a < 4; a++) begin
        oct_t[s][a] = 3'd0; note_t[s][a] = 3'd0; len_t[s][a] = 4'd0;
      end
    end
    oct_t[1][0] = 3'd2; note_t[1][0] = 3'd1; len_t[1][0] = 4'd1;
    oct_t[1][1] = 3'd4; note_t[1][1] = 3'd3; len_t[1][1] = 4'd2;
    oct_t[1][2] = 3'd1; note_t[1][2] = 3'd5; len_t[1][2] = 4'd1;
    tl_t[1] = 8'd3;
    oct_t[2][0] = 3'd3; note_t[2][0] = 3'd0; len_t[2][0] = 4'd1;   // rest
    tl_t[2] = 8'd1;
    oct_t[3][0] = 3'd5; note_t[3][0] = 3'd2; len_t[3][0] = 4'd0;   // length 0 -> 1
    tl_t[3] = 8'd1;
    tl_t[4] = 8'd0;                                               // empty song

    //             song mod n pnote plen  gate        per          win
    vecs[0] = mk(1, 0, 3, -1, 0,   4,  8, 4,   7, 11,  6,   3, 3, 3);
    vecs[1] = mk(1, 2, 3, -1, 0,   8, 16, 8,  11, 19, 10,   3, 3, 3);
    vecs[2] = mk(1, 3, 3, -1, 0,   2,  4, 2,   5,  7,  4,   2, 3, 2);
    vecs[3] = mk(1, 0, 3,  1, 5,   4,  8, 4,   7, 16,  6,   3, 3, 3);
    vecs[4] = mk(2, 0, 1, -1, 0,   0,  0, 0,   6,  0,  0,   3, 0, 0);
    vecs[5] = mk(3, 0, 1, -1, 0,   4,  0, 0,   6,  0,  0,   3, 0, 0);
    vecs[6] = mk(3, 3, 1, -1, 0,   2,  0, 0,   4,  0,  0,   2, 0, 0);

    // Reset state, observed before any clock edge
    #1 rst = 1'b1;
    #1 chk("reset_outputs", out_word(), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // abort together with start
    @(negedge clk);
    song_sel = 3'd1; mod = 2'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start_busy", int'(busy), 0);
    @(negedge clk);
    chk("abort_beats_start_stay", int'(busy), 0);

    // abort during the first GAP
    song_sel = 3'd1; mod = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; seen = 0;
    while (cnt < 50) begin
      if (note_strobe) seen = 1;
      if (seen == 1 && busy && !snd_gate) break;
      @(negedge clk);
      cnt++;
    end
    chk("gap_reached", int'(cnt < 50), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_gap_busy", int'(busy), 0);
    chk("abort_gap_outs", int'({snd_gate, window_open, note_strobe, finished}), 0);
    chk("abort_gap_addr", int'(rom_addr), 0);
    fin_c = 0; busy_c = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (finished) fin_c++;
      if (busy) busy_c++;
    end
    chk("abort_gap_no_finish", fin_c, 0);
    chk("abort_gap_stays_idle", busy_c, 0);

    // empty song: finished two cycles after start, no strobe
    song_sel = 3'd4; mod = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_c1_finished", int'(finished), 0);
    chk("empty_c1_busy", int'(busy), 1);
    @(negedge clk);
    chk("empty_c2_finished", int'(finished), 1);
    chk("empty_c2_strobe", int'(note_strobe), 0);
    @(negedge clk);
    chk("empty_c3_busy", int'({busy, finished}), 0);

    // asynchronous reset mid-PLAY
    song_sel = 3'd1; mod = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (cnt < 50 && !snd_gate) begin
      @(negedge clk);
      cnt++;
    end
    chk("play_reached", int'(snd_gate), 1);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", out_word(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
